// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame streamer: geometry defaults,
// FSM state encoding, SSD1306 addressing command bytes and a bit-reverse helper.
// Ports: none (package).
package oled_pkg;

    localparam int H_PIXELS_DEF       = 128;
    localparam int V_PIXELS_DEF       = 64;
    localparam int TIMEOUT_CYCLES_DEF = 31;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_REQ  = 3'd2,
        ST_GAP  = 3'd3,
        ST_SEND = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // SSD1306 addressing commands
    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

    localparam int PREAMBLE_LEN = 6;

    // Framebuffer bytes carry the top row in bit7; SSD1306 wants it in bit0.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Address-window preamble: full column range, then full page range.
    function automatic logic [7:0] preamble_byte(input logic [2:0] idx,
                                                 input logic [7:0] col_last,
                                                 input logic [7:0] page_last);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_COL_ADDR;
            3'd1:    b = 8'h00;
            3'd2:    b = col_last;
            3'd3:    b = CMD_PAGE_ADDR;
            3'd4:    b = 8'h00;
            3'd5:    b = page_last;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_frame_streamer.sv
// Purpose: walks the framebuffer in SSD1306 page order (pages x columns), one
// column-mode read per byte, bit-reverses each byte and hands it to the SPI
// byte transmitter over tx_valid/tx_ready.
// Ports: clk/rst (async active-low); start/busy/frame_done/err control;
// fb_* framebuffer read port; tx_valid/tx_ready/tx_data/tx_dc transmitter port.
// Optional: OLED_STREAMER_PREAMBLE_EN sends a 6-byte column/page address
// command preamble (tx_dc=0) before the data bytes of each frame.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int H_PIXELS       = H_PIXELS_DEF,
    parameter int V_PIXELS       = V_PIXELS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    output logic       err,
    output logic       fb_re,
    output logic       fb_r_mode,
    output logic [7:0] fb_r_xpos,
    output logic [7:0] fb_r_ypos,
    input  logic       fb_r_data_valid,
    input  logic [7:0] fb_dout,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_dc
);

    localparam int PAGES  = V_PIXELS / 8;
    localparam int COL_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_PIXELS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);
    // The counter value seen on the last permitted REQ cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_dc_q, tx_dc_d;

`ifdef OLED_STREAMER_PREAMBLE_EN
    logic [2:0]          pre_idx_q, pre_idx_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            page_q     <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_dc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            page_q     <= page_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_dc_q    <= tx_dc_d;
        end
    end

`ifdef OLED_STREAMER_PREAMBLE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_idx_q <= 3'd0;
        end else begin
            pre_idx_q <= pre_idx_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        page_d     = page_q;
        wait_d     = wait_q;
        err_d      = err_q;
        busy_d     = busy_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_dc_d    = tx_dc_q;
`ifdef OLED_STREAMER_PREAMBLE_EN
        pre_idx_d  = pre_idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    col_d  = '0;
                    page_d = '0;
                    wait_d = '0;
                    busy_d = 1'b1;
`ifdef OLED_STREAMER_PREAMBLE_EN
                    // First command byte is presented straight away.
                    state_d    = ST_PRE;
                    pre_idx_d  = 3'd0;
                    tx_valid_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_data_d  = preamble_byte(3'd0, 8'(COL_LAST), 8'(PAGE_LAST));
`else
                    state_d = ST_REQ;
`endif
                end
            end

`ifdef OLED_STREAMER_PREAMBLE_EN
            ST_PRE: begin
                if (tx_ready) begin
                    if (pre_idx_q == 3'(PREAMBLE_LEN - 1)) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_REQ;
                    end else begin
                        pre_idx_d = pre_idx_q + 3'd1;
                        tx_data_d = preamble_byte(pre_idx_q + 3'd1,
                                                  8'(COL_LAST), 8'(PAGE_LAST));
                    end
                end
            end
`endif

            ST_REQ: begin
                if (fb_r_data_valid) begin
                    tx_data_d = bit_rev8(fb_dout);
                    tx_dc_d   = 1'b1;
                    wait_d    = '0;
                    state_d   = ST_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    // Framebuffer never answered: send a blank column.
                    tx_data_d = 8'h00;
                    tx_dc_d   = 1'b1;
                    err_d     = 1'b1;
                    wait_d    = '0;
                    state_d   = ST_GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            // One idle cycle with re low lets the framebuffer flush its
            // read pipeline before the next column request.
            ST_GAP: begin
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        col_d = '0;
                        if (page_q != PAGE_LAST) begin
                            page_d  = page_q + 1'b1;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign frame_done = (state_q == ST_DONE);
    assign err        = err_q;
    assign fb_re      = (state_q == ST_REQ);
    assign fb_r_mode  = 1'b1;
    assign fb_r_xpos  = 8'(col_q);
    assign fb_r_ypos  = 8'({page_q, 3'b000});
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_dc      = tx_dc_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
module tb_oled_frame_streamer;

`ifdef OLED_STREAMER_PREAMBLE_EN
    localparam int PRE_N = 6;
`else
    localparam int PRE_N = 0;
`endif
    localparam int FB_LAT = 2;
    localparam int NBYTES = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       busy, frame_done, err;
    logic       fb_re, fb_r_mode;
    logic [7:0] fb_r_xpos, fb_r_ypos;
    logic       fb_r_data_valid = 1'b0;
    logic [7:0] fb_dout = 8'h00;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_dc;

    oled_frame_streamer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .frame_done      (frame_done),
        .err             (err),
        .fb_re           (fb_re),
        .fb_r_mode       (fb_r_mode),
        .fb_r_xpos       (fb_r_xpos),
        .fb_r_ypos       (fb_r_ypos),
        .fb_r_data_valid (fb_r_data_valid),
        .fb_dout         (fb_dout),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .tx_dc           (tx_dc)
    );

    always #5 clk = ~clk;

    // Framebuffer contents in column-read format: bit7 = top row of the page.
    logic [7:0] fbmem [0:7][0:127];
    logic [8:0] rec [0:2047];
    int  n_bytes = 0;
    int  done_cnt = 0;
    int  bytes_at_done = 0;
    int  fb_cnt = 0;
    bit  blk_en = 1'b0;
    int  stall_left = 0;
    int  stall_viol = 0;
    int  viol_re_tx = 0;
    int  viol_gap = 0;
    bit  prev_rd_done = 1'b0;
    logic [7:0] ref_dat;
    logic       ref_dc;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_fb();
        for (int p = 0; p < 8; p++)
            for (int c = 0; c < 128; c++)
                fbmem[p][c] = 8'h00;
    endtask

    task automatic set_pixel(input int x, input int y);
        logic [7:0] m;
        m = 8'h80;
        fbmem[y/8][x] = fbmem[y/8][x] | (m >> (y % 8));
    endtask

    task automatic clear_rec();
        n_bytes = 0;
        done_cnt = 0;
        bytes_at_done = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic analyze(input string tag, input int hot_idx, input logic [7:0] hot_val);
        int bad;
        logic [7:0] e;
`ifdef OLED_STREAMER_PREAMBLE_EN
        logic [7:0] pre_exp [0:5];
        int pbad;
        pre_exp = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        pbad = 0;
        for (int k = 0; k < 6; k++)
            if (rec[k] !== {1'b0, pre_exp[k]}) pbad++;
        check({tag, "_preamble_bad"}, pbad, 0);
`endif
        bad = 0;
        for (int i = 0; i < NBYTES; i++) begin
            e = (i == hot_idx) ? hot_val : 8'h00;
            if (rec[PRE_N + i] !== {1'b1, e}) bad++;
        end
        check({tag, "_count"}, n_bytes, PRE_N + NBYTES);
        check({tag, "_bad_bytes"}, bad, 0);
        check({tag, "_hot_byte"}, rec[PRE_N + hot_idx], {1'b1, hot_val});
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_bytes_at_done"}, bytes_at_done, PRE_N + NBYTES);
    endtask

    // Transmitter sink and framebuffer model, evaluated at negedge for the
    // upcoming rising edge.
    always @(negedge clk) begin
        if (stall_left > 0 && tx_valid && n_bytes == 0) begin
            tx_ready = 1'b0;
            if (stall_left == 20) begin
                ref_dat = tx_data;
                ref_dc  = tx_dc;
            end else if (tx_data !== ref_dat || tx_dc !== ref_dc) begin
                stall_viol++;
            end
            stall_left--;
        end else begin
            if (stall_left > 0 && stall_left < 20) stall_viol++;
            tx_ready = 1'b1;
        end

        if (tx_valid && tx_ready) begin
            if (n_bytes < 2048) rec[n_bytes] = {tx_dc, tx_data};
            n_bytes++;
        end
        if (frame_done) begin
            done_cnt++;
            bytes_at_done = n_bytes;
        end

        if (fb_re) begin
            if (tx_valid) viol_re_tx++;
            if (prev_rd_done) viol_gap++;
            fb_cnt++;
            if (fb_cnt >= FB_LAT && !(blk_en && fb_r_xpos == 8'd3)) begin
                fb_r_data_valid = 1'b1;
                fb_dout = fbmem[fb_r_ypos[5:3]][fb_r_xpos[6:0]];
            end else begin
                fb_r_data_valid = 1'b0;
            end
        end else begin
            fb_cnt = 0;
            fb_r_data_valid = 1'b0;
        end
        prev_rd_done = fb_re && fb_r_data_valid;
    end

    initial begin
        int cyc;
        rst = 1'b0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_fb_re", fb_re, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_dc", tx_dc, 0);
        check("rst_xpos", fb_r_xpos, 8'h00);
        check("rst_ypos", fb_r_ypos, 8'h00);
        #20 rst = 1'b1;

        // Pixel (0,0) only: first data byte 0x01.
        clear_fb();
        set_pixel(0, 0);
        clear_rec();
        pulse_start();
        check("a_busy_after_start", busy, 1);
        check("a_mode", fb_r_mode, 1);
        wait_done("a");
        analyze("a", 0, 8'h01);
        check("a_busy_after", busy, 0);
        check("a_err", err, 0);

        // Pixel (5,13): page 1 col 5 -> index 133 value 0x20, with a
        // 20-cycle stall on the first transfer and an ignored second start.
        clear_fb();
        set_pixel(5, 13);
        clear_rec();
        stall_left = 20;
        viol_re_tx = 0;
        viol_gap = 0;
        pulse_start();
        repeat (50) @(posedge clk);
        pulse_start();
        wait_done("b");
        analyze("b", 133, 8'h20);
        check("b_stall_used", stall_left, 0);
        check("b_stall_stable", stall_viol, 0);
        check("b_re_during_tx", viol_re_tx, 0);
        check("b_re_gap", viol_gap, 0);
        repeat (100) @(posedge clk);
        #1;
        check("b_no_queued_frame", done_cnt, 1);
        check("b_busy_idle", busy, 0);

        // Column 3 never answers: blank bytes, err set, frame completes.
        clear_fb();
        set_pixel(3, 0);
        clear_rec();
        blk_en = 1'b1;
        pulse_start();
        wait_done("c");
        analyze("c", 3, 8'h00);
        check("c_err_set", err, 1);
        blk_en = 1'b0;

        // Next start clears err; reset mid-frame abandons it.
        clear_fb();
        set_pixel(0, 0);
        clear_rec();
        pulse_start();
        check("d_err_cleared", err, 0);
        cyc = 0;
        while (n_bytes < 500 && cyc < 10000) begin
            @(posedge clk);
            cyc++;
        end
        check("d_reached_500", (n_bytes >= 500), 1);
        #1 rst = 1'b0;
        #1;
        check("d_rst_tx_valid", tx_valid, 0);
        check("d_rst_busy", busy, 0);
        check("d_rst_fb_re", fb_re, 0);
        check("d_rst_tx_data", tx_data, 8'h00);
        check("d_rst_ypos", fb_r_ypos, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("d_no_stale_done", done_cnt, 0);
        clear_rec();
        pulse_start();
        wait_done("e");
        analyze("e", 0, 8'h01);
        check("e_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
Downstream consumer of the monochrome framebuffer. On `start`, it walks the framebuffer in SSD1306 page order: 8 pages × 128 columns, one column-mode read per byte. Each read byte is converted to SSD1306 page format (LSB = top row) and handed to the OLED SPI byte transmitter over a valid/ready handshake. `busy` lets the draw-side logic hold off framebuffer writes during a scan.

Parameters:
H_PIXELS, 128, display width in pixels; also the number of columns per page.
V_PIXELS, 64, display height in pixels; page count = V_PIXELS/8.
TIMEOUT_CYCLES, 31, maximum cycles to wait for fb_r_data_valid before substituting 0x00.

Ports:
clk  in  1  module clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to stream a frame; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last byte transfers
err  out  1  sticky; set on any read timeout, cleared by an accepted start
fb_re  out  1  framebuffer read enable
fb_r_mode  out  1  framebuffer read mode; tied to 1 (column read)
fb_r_xpos  out  8  column being read
fb_r_ypos  out  8  page*8
fb_r_data_valid  in  1  framebuffer read data valid
fb_dout  in  8  framebuffer column byte; bit7 = row ypos, bit0 = row ypos+7
tx_valid  out  1  byte available for the SPI transmitter
tx_ready  in  1  SPI transmitter accepts the byte
tx_data  out  8  byte to transmit
tx_dc  out  1  SSD1306 D/C flag: 1 = display data, 0 = command

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, col=0, page=0, err=0, wait counter=0. A reset mid-frame abandons the frame; no frame_done is issued.
- States: IDLE, PRE, REQ, GAP, SEND, DONE.
- IDLE: start=1 → err<=0, col<=0, page<=0, busy<=1, then PRE if the feature is enabled, else REQ.
- REQ: drive fb_re=1, fb_r_xpos=col, fb_r_ypos=page*8; wait counter increments each cycle.
  - fb_r_data_valid=1 → capture tx_data[i] = fb_dout[7-i], tx_dc=1, go to GAP.
  - Wait counter reaches TIMEOUT_CYCLES first → tx_data=0x00, tx_dc=1, err<=1, go to GAP.
- GAP: fb_re=0 for exactly one cycle. This is mandatory: the framebuffer clears its read pipeline only while re is low. Next state SEND with tx_valid=1.
- SEND: hold tx_valid, tx_data and tx_dc stable until tx_valid&&tx_ready. On transfer, tx_valid<=0 and the position advances:
  - col<H_PIXELS-1 → col+1, REQ.
  - Else col<=0; if page<V_PIXELS/8-1 → page+1, REQ; else DONE.
- DONE: frame_done=1 for one cycle, busy<=0, IDLE.
- start while busy: ignored, no queuing.
- Counter widths: col is clog2(H_PIXELS) bits, page is clog2(V_PIXELS/8) bits, wait counter is clog2(TIMEOUT_CYCLES+1) bits; all zero-extended onto the 8-bit ports.
- Byte count: exactly H_PIXELS*V_PIXELS/8 = 1024 data bytes per frame, in the order page 0 col 0..127, page 1 col 0..127, …
- Minimum per-byte latency: framebuffer column latency (~11 cycles) + GAP + 1 SEND cycle.
- fb_re is 0 in every state except REQ.

Optional Feature:
Macro OLED_STREAMER_PREAMBLE_EN.
- Defined: PRE state emits 6 command bytes with tx_dc=0, using the same valid/ready rules: 0x21, 0x00, H_PIXELS-1, 0x22, 0x00, V_PIXELS/8-1. Then REQ.
- Undefined: PRE state and its 3-bit index counter are absent; IDLE goes straight to REQ and only data bytes are sent.

Decomposition:
- Shared package oled_pkg: H_PIXELS/V_PIXELS defaults, state encoding constants, SSD1306 command constants (0x21 column address, 0x22 page address), bit-reverse function.
- No sub-module; the FSM plus counters is a single module.

Test Plan:
- Framebuffer model with only pixel (0,0) set, tx_ready=1 → 1024 bytes; byte 0 = 0x01, all others 0x00; frame_done pulses once after byte 1023; busy low afterwards.
- Only pixel (x=5, y=13) set → byte index 133 (page 1, col 5) = 0x20; all others 0x00.
- tx_ready held 0 for 20 cycles on byte 0 → tx_valid, tx_data, tx_dc stable throughout; no fb_re asserted during the stall; fb_re low for ≥1 cycle between consecutive reads.
- Framebuffer model never asserts valid for col 3 → after 31 cycles byte 3 = 0x00, err=1, frame still completes; next start clears err.
- rst=0 pulsed at byte 500, then start → outputs 0 immediately, new frame begins at page 0 col 0 with 1024 bytes and no stale frame_done.
- OLED_STREAMER_PREAMBLE_EN defined → first 6 transfers have tx_dc=0: 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07; then 1024 bytes with tx_dc=1.
